simple_mem_arbiter: RTL
=======================

Name: simple_mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared 32-bit x 64-entry memory (memory_32_6 datapath).
- After reset it zero-fills the whole memory, then grants one access per cycle to requester 0 or 1 using round-robin priority.
- It returns read data to the requester that issued the read.
- Sits between the two client blocks and the memory instance; the memory is single-access per cycle.

Parameters:
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 6, memory address width; depth = 2**ADDR_WIDTH = 64
- READ_LATENCY, 1, cycles from mem_rd_en to valid mem_rd_data (1..4)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- req0_valid  input  1  requester 0 has an access pending
- req0_write  input  1  1 = write, 0 = read
- req0_addr  input  ADDR_WIDTH  access address
- req0_wr_data  input  DATA_WIDTH  write data
- req0_ready  output  1  grant; the request is accepted when valid & ready
- rsp0_valid  output  1  read data for requester 0 is valid this cycle
- rsp0_data  output  DATA_WIDTH  read data for requester 0
- req1_*/rsp1_*  same set as requester 0, for requester 1
- mem_wr_en  output  1  memory write strobe
- mem_wr_addr  output  ADDR_WIDTH  memory write address
- mem_wr_data  output  DATA_WIDTH  memory write data
- mem_rd_en  output  1  memory read strobe
- mem_rd_addr  output  ADDR_WIDTH  memory read address
- mem_rd_data  input  DATA_WIDTH  memory read data, valid READ_LATENCY cycles after mem_rd_en
- init_done  output  1  high once zero-fill is complete

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - reset is synchronous and active-high.
  - On reset: state=INIT, init_cnt=0, rr_ptr=0 (requester 0 favoured), response pipeline cleared.
- Output values while reset is asserted: req*_ready=0, rsp*_valid=0, rsp*_data=0, mem_wr_en=0, mem_rd_en=0, init_done=0.
- State machine: INIT -> RUN.
- INIT state:
  - Each cycle: mem_wr_en=1, mem_wr_addr=init_cnt, mem_wr_data=0; init_cnt increments.
  - After writing address 63, the next state is RUN and init_done=1.
  - INIT lasts exactly 64 cycles after reset deasserts.
  - req*_ready=0 throughout INIT.
- RUN state: init_done=1 until the next reset.
- Arbitration (combinational, registered pointer):
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester indicated by rr_ptr wins; the loser's ready=0.
  - Neither valid: no grant, rr_ptr unchanged.
  - On every accepted request, rr_ptr <= index of the non-granted requester.
  - Two continuously requesting clients therefore alternate 0,1,0,1...
- req*_ready is a function of the valids and rr_ptr only; it must not depend on the requester's own ready.
- Requesters hold valid and payload stable until accepted.
- Memory access, same cycle as acceptance:
  - Write: mem_wr_en=1, mem_wr_addr/mem_wr_data taken from the winner.
  - Read: mem_rd_en=1, mem_rd_addr taken from the winner.
  - Never more than one mem_*_en asserted per cycle.
- Response pipeline:
  - Shift register of depth READ_LATENCY carrying {valid, requester id}.
  - When a tag emerges, the matching rsp*_valid=1 and rsp*_data=mem_rd_data, combinational in that cycle.
  - Read response latency is READ_LATENCY cycles after acceptance.
  - Back-to-back reads are fully pipelined, one response per cycle, in issue order.
  - No backpressure on responses; requesters must always accept them.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data (memory write-first ordering is guaranteed by the memory; the arbiter adds no bypass).
- Reset during RUN: in-flight responses are discarded (no rsp*_valid), and INIT restarts from address 0.
- Address width: all addresses are ADDR_WIDTH bits and wrap naturally; there is no range checking.

Test Plan:
- Reset, then idle for 70 cycles -> mem_wr_en high for exactly 64 cycles with addresses 0..63 and data 0; init_done rises on cycle 65; no ready during INIT.
- After init, requester 0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> rsp0_valid exactly 1 cycle after read acceptance with 0xDEADBEEF; rsp1_valid stays 0.
- Both requesters issue 4 continuous reads each (addrs 0-3 and 10-13) -> grants alternate 0,1,0,1,... starting with 0; each response is routed to the correct port in order.
- Read of any never-written address (e.g. 63) after init -> data 0x00000000.
- Only requester 1 valid for 5 cycles -> 5 consecutive grants to 1; then both valid -> requester 0 granted first.
- Reset asserted one cycle after a read is accepted -> no rsp valid emerges; INIT restarts at addr 0; run with READ_LATENCY=3 and check 3-cycle response latency.

Source files
------------

// File: rtl/simple_mem_arbiter.sv
// simple_mem_arbiter
// Two-requester round-robin arbiter and sequencer for a single-port-per-cycle
// 32 x 64 memory. After reset the whole memory is zero-filled. Then at most one
// access per cycle is granted, and read data is routed back to the requester
// that issued the read, READ_LATENCY cycles after acceptance.

module simple_mem_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 6,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  req0_valid,
   input  logic                  req0_write,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wr_data,
   output logic                  req0_ready,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_data,

   input  logic                  req1_valid,
   input  logic                  req1_write,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wr_data,
   output logic                  req1_ready,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_data,

   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,

   output logic                  init_done
);

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   init_cnt;
   logic                    done_q;
   logic                    rr_ptr;

   logic                    run_active;
   logic                    grant0;
   logic                    grant1;
   logic                    accept;
   logic                    win_write;
   logic [ADDR_WIDTH-1:0]   win_addr;
   logic [DATA_WIDTH-1:0]   win_data;
   logic                    rd_accept;

   logic [READ_LATENCY-1:0] pipe_valid;
   logic [READ_LATENCY-1:0] pipe_id;
   logic                    tail_valid;
   logic                    tail_id;

   // Grants are only possible in RUN and are suppressed in the reset cycle itself,
   // so nothing reaches the memory while reset is being applied.
   assign run_active = (state == ST_RUN) && !reset;

   // Sequencer: walk init_cnt over every address once, then stay in RUN until reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_INIT;
         init_cnt <= '0;
         done_q   <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (init_cnt == {ADDR_WIDTH{1'b1}}) begin
                  state  <= ST_RUN;
                  done_q <= 1'b1;
               end
            end
            ST_RUN: begin
               done_q <= 1'b1;
            end
            default: begin
               state    <= ST_INIT;
               init_cnt <= '0;
               done_q   <= 1'b0;
            end
         endcase
      end
   end

   // init_done reads low during the reset cycle even though done_q only clears on the edge.
   assign init_done = done_q && !reset;

   // Round-robin choice: a lone requester always wins, a tie goes to rr_ptr.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (run_active) begin
         if (req0_valid && (!req1_valid || (rr_ptr == 1'b0))) begin
            grant0 = 1'b1;
         end else if (req1_valid) begin
            grant1 = 1'b1;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign accept     = grant0 || grant1;

   // Select the winning requester's command fields.
   always_comb begin
      win_write = 1'b0;
      win_addr  = '0;
      win_data  = '0;
      if (grant0) begin
         win_write = req0_write;
         win_addr  = req0_addr;
         win_data  = req0_wr_data;
      end else if (grant1) begin
         win_write = req1_write;
         win_addr  = req1_addr;
         win_data  = req1_wr_data;
      end
   end

   assign rd_accept = accept && !win_write;

   // Pointer moves to the loser after every accepted access, and is left alone when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= 1'b0;
      end else if (accept) begin
         rr_ptr <= grant0 ? 1'b1 : 1'b0;
      end
   end

   // Drive the memory: zero-fill sweep while initialising, otherwise the granted access.
   always_comb begin
      mem_wr_en   = 1'b0;
      mem_wr_addr = '0;
      mem_wr_data = '0;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      if ((state == ST_INIT) && !reset) begin
         mem_wr_en   = 1'b1;
         mem_wr_addr = init_cnt;
         mem_wr_data = '0;
      end else if (accept) begin
         if (win_write) begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = win_addr;
            mem_wr_data = win_data;
         end else begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = win_addr;
         end
      end
   end

   // Response tag pipeline: one {valid, id} stage per cycle of memory read latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_valid <= '0;
         pipe_id    <= '0;
      end else begin
         pipe_valid[0] <= rd_accept;
         pipe_id[0]    <= grant1;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_id[i]    <= pipe_id[i-1];
         end
      end
   end

   assign tail_valid = pipe_valid[READ_LATENCY-1] && !reset;
   assign tail_id    = pipe_id[READ_LATENCY-1];

   // Route the emerging read data to whichever requester issued it; data reads zero otherwise.
   always_comb begin
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      rsp0_data  = '0;
      rsp1_data  = '0;
      if (tail_valid) begin
         if (tail_id == 1'b0) begin
            rsp0_valid = 1'b1;
            rsp0_data  = mem_rd_data;
         end else begin
            rsp1_valid = 1'b1;
            rsp1_data  = mem_rd_data;
         end
      end
   end

endmodule
